// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, memory mode codes and the
// data-port access qualifier.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StData  = 2'd1,
        StInstr = 2'd2
    } arb_state_t;

    typedef logic [2:0] mem_mode_t;

    // Access-size codes used by the core; the arbiter passes them through untouched.
    localparam mem_mode_t MemModeByte  = 3'b000;
    localparam mem_mode_t MemModeHalf  = 3'b001;
    localparam mem_mode_t MemModeWord  = 3'b010;
    localparam mem_mode_t MemModeByteU = 3'b100;

    function automatic logic dmem_access(input logic en, input logic rd, input logic wr);
        return en & (rd | wr);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports plus the shared memory bus, bundled for the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import mem_arbiter_pkg::*;

    logic [ADDR_WIDTH-1:0] imem_address;
    logic                  imem_enable;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  imem_wait;

    logic [ADDR_WIDTH-1:0] dmem_address;
    logic                  dmem_enable;
    logic [DATA_WIDTH-1:0] dmem_write_data;
    logic                  dmem_write_enable;
    mem_mode_t             dmem_write_mode;
    logic                  dmem_read_enable;
    mem_mode_t             dmem_read_mode;
    logic [DATA_WIDTH-1:0] dmem_read_data;
    logic                  dmem_wait;

    logic                  bus_req;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic                  bus_write;
    mem_mode_t             bus_mode;
    logic [DATA_WIDTH-1:0] bus_write_data;
    logic [DATA_WIDTH-1:0] bus_read_data;
    logic                  bus_ack;

    // Arbiter view.
    modport slave (
        input  imem_address, imem_enable,
        input  dmem_address, dmem_enable, dmem_write_data, dmem_write_enable, dmem_write_mode,
        input  dmem_read_enable, dmem_read_mode,
        input  bus_read_data, bus_ack,
        output imem_data, imem_wait, dmem_read_data, dmem_wait,
        output bus_req, bus_address, bus_write, bus_mode, bus_write_data
    );

    // Core + memory view.
    modport master (
        output imem_address, imem_enable,
        output dmem_address, dmem_enable, dmem_write_data, dmem_write_enable, dmem_write_mode,
        output dmem_read_enable, dmem_read_mode,
        output bus_read_data, bus_ack,
        input  imem_data, imem_wait, dmem_read_data, dmem_wait,
        input  bus_req, bus_address, bus_write, bus_mode, bus_write_data
    );

endinterface

// File: rtl/mem_arbiter_req_latch.sv
// One captured request: a pending flag plus the fields latched on the capture edge.
module arb_req_latch #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             capture_i,
    input  logic             clear_i,
    input  logic [Width-1:0] fields_i,
    output logic             pend_o,
    output logic [Width-1:0] fields_o
);

    logic             pend_q, pend_d;
    logic [Width-1:0] fields_q, fields_d;

    // A strobe while already pending is dropped; clear only ever fires while pending.
    always_comb begin
        pend_d   = pend_q;
        fields_d = fields_q;
        if (clear_i) begin
            pend_d = 1'b0;
        end else if (capture_i && !pend_q) begin
            pend_d   = 1'b1;
            fields_d = fields_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= 1'b0;
            fields_q <= '0;
        end else begin
            pend_q   <= pend_d;
            fields_q <= fields_d;
        end
    end

    assign pend_o   = pend_q;
    assign fields_o = fields_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one req/ack memory bus, data first.
// Define MEM_ARB_STATS_EN to add saturating stall counters stat_istall/stat_dstall.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_arbiter_if.slave          io
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_istall,
    output logic [STAT_WIDTH-1:0] stat_dstall
`endif
);

    localparam int unsigned DFieldW = 1 + 3 + DATA_WIDTH + ADDR_WIDTH;

    arb_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] imem_data_q, imem_data_d;
    logic [DATA_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;

    logic                  i_cap, d_cap, i_clr, d_clr, i_pend, d_pend;
    logic [ADDR_WIDTH-1:0] i_addr, d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_write;
    mem_mode_t             d_mode;
    logic [DFieldW-1:0]    d_fields_in, d_fields;

    assign i_cap = io.imem_enable;
    assign d_cap = dmem_access(io.dmem_enable, io.dmem_read_enable, io.dmem_write_enable);

    // Write wins when both flags are set.
    assign d_fields_in = {io.dmem_write_enable,
                          io.dmem_write_enable ? io.dmem_write_mode : io.dmem_read_mode,
                          io.dmem_write_data, io.dmem_address};

    arb_req_latch #(
        .Width (ADDR_WIDTH)
    ) u_ireq (
        .clk       (clk),
        .reset_n   (reset_n),
        .capture_i (i_cap),
        .clear_i   (i_clr),
        .fields_i  (io.imem_address),
        .pend_o    (i_pend),
        .fields_o  (i_addr)
    );

    arb_req_latch #(
        .Width (DFieldW)
    ) u_dreq (
        .clk       (clk),
        .reset_n   (reset_n),
        .capture_i (d_cap),
        .clear_i   (d_clr),
        .fields_i  (d_fields_in),
        .pend_o    (d_pend),
        .fields_o  (d_fields)
    );

    assign {d_write, d_mode, d_wdata, d_addr} = d_fields;

    // Capture-edge strobes feed the grant so bus_req rises on the same edge as capture.
    always_comb begin
        state_d      = state_q;
        i_clr        = 1'b0;
        d_clr        = 1'b0;
        imem_data_d  = imem_data_q;
        dmem_rdata_d = dmem_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (d_pend || d_cap) begin
                    state_d = StData;
                end else if (i_pend || i_cap) begin
                    state_d = StInstr;
                end
            end
            StData: begin
                if (io.bus_ack) begin
                    d_clr = 1'b1;
                    if (!d_write) begin
                        dmem_rdata_d = io.bus_read_data;
                    end
                    state_d = (i_pend || i_cap) ? StInstr : StIdle;
                end
            end
            StInstr: begin
                if (io.bus_ack) begin
                    i_clr       = 1'b1;
                    imem_data_d = io.bus_read_data;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            imem_data_q  <= '0;
            dmem_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            imem_data_q  <= imem_data_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    assign io.bus_req        = (state_q != StIdle);
    assign io.bus_address    = (state_q == StData) ? d_addr : i_addr;
    assign io.bus_write      = (state_q == StData) && d_write;
    assign io.bus_mode       = (state_q == StData) ? d_mode : MemModeWord;
    assign io.bus_write_data = (state_q == StData) ? d_wdata : '0;

    assign io.imem_data      = imem_data_q;
    assign io.dmem_read_data = dmem_rdata_q;
    assign io.imem_wait      = i_pend;
    assign io.dmem_wait      = d_pend;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] istall_q, istall_d, dstall_q, dstall_d;

    always_comb begin
        istall_d = istall_q;
        dstall_d = dstall_q;
        if (i_pend && (istall_q != '1)) begin
            istall_d = istall_q + STAT_WIDTH'(1);
        end
        if (d_pend && (dstall_q != '1)) begin
            dstall_d = dstall_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            istall_q <= '0;
            dstall_q <= '0;
        end else begin
            istall_q <= istall_d;
            dstall_q <= dstall_d;
        end
    end

    assign stat_istall = istall_q;
    assign stat_dstall = dstall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_istall, stat_dstall;
`endif

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
`ifdef MEM_ARB_STATS_EN
        ,
        .STAT_WIDTH (32)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .io          (bus_if.slave)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_istall (stat_istall),
        .stat_dstall (stat_dstall)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  mode;
        logic [31:0] wdata;
        bit          is_data;
    } xfer_t;

    xfer_t       exp_q[$];
    int          dly_q[$];
    logic [31:0] bus_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] exp_imem = '0;
    logic [31:0] exp_dmem = '0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory responder: acks each bus transfer after a chosen number of cycles.
    logic        resp_ack = 1'b0, spur_ack = 1'b0;
    logic [31:0] resp_rd = '0, spur_rd = '0;
    bit          resp_en = 1'b1, rand_dly = 1'b0;
    int          ack_delay = 1;

    assign bus_if.bus_ack       = resp_ack | spur_ack;
    assign bus_if.bus_read_data = spur_ack ? spur_rd : resp_rd;

    initial begin : responder
        int          cnt = 0;
        int          dly = 1;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_ctrl;
        xfer_t       e;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                cnt      = 0;
            end
            if (!reset_n || !resp_en) begin
                cnt = 0;
            end else if (bus_if.bus_req) begin
                cnt++;
                if (cnt == 1) begin
                    s_addr  = bus_if.bus_address;
                    s_wdata = bus_if.bus_write_data;
                    s_ctrl  = {bus_if.bus_write, bus_if.bus_mode};
                    dly     = rand_dly ? int'($urandom_range(4, 1)) : ack_delay;
                    dly_q.push_back(dly);
                end
                if (cnt == dly) begin
                    if (dly > 1) begin
                        chk("bus_addr_stable", bus_if.bus_address, s_addr);
                        chk("bus_ctrl_stable", {28'b0, bus_if.bus_write, bus_if.bus_mode},
                            {28'b0, s_ctrl});
                        chk("bus_wdata_stable", bus_if.bus_write_data, s_wdata);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got transfer to %h, expected none",
                                 bus_if.bus_address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_addr", bus_if.bus_address, e.addr);
                        chk("xfer_write", {31'b0, bus_if.bus_write}, {31'b0, e.write});
                        if (e.is_data) chk("xfer_mode", {29'b0, bus_if.bus_mode}, {29'b0, e.mode});
                        if (e.write) chk("xfer_wdata", bus_if.bus_write_data, e.wdata);
                    end
                    if (bus_if.bus_write) bus_mem[bus_if.bus_address] = bus_if.bus_write_data;
                    else resp_rd = bus_rd(bus_if.bus_address);
                    resp_ack = 1'b1;
                end
            end
        end
    end

    // A correct core never strobes a port whose wait is high.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(bus_if.imem_enable && bus_if.imem_wait))
                else $error("imem strobe while imem_wait high");
            assert (!(bus_if.dmem_enable && bus_if.dmem_wait &&
                      (bus_if.dmem_read_enable || bus_if.dmem_write_enable)))
                else $error("dmem strobe while dmem_wait high");
        end
    end

    // One core cycle of requests, then wait for both ports to drain; called at posedge+1.
    task automatic do_op(input bit fen, input logic [31:0] faddr, input bit den, input bit re,
                         input bit we, input logic [31:0] daddr, input logic [31:0] wdata,
                         input logic [2:0] wmode, input logic [2:0] rmode,
                         output int istall, output int dstall);
        xfer_t e;
        bit    dacc = den && (re || we);
        int    n = 0;
        dly_q.delete();
        if (dacc) begin
            e.addr = daddr; e.write = we; e.mode = we ? wmode : rmode;
            e.wdata = wdata; e.is_data = 1'b1;
            exp_q.push_back(e);
        end
        if (fen) begin
            e.addr = faddr; e.write = 1'b0; e.mode = MemModeWord;
            e.wdata = '0; e.is_data = 1'b0;
            exp_q.push_back(e);
        end
        bus_if.imem_enable       = fen;
        bus_if.imem_address      = faddr;
        bus_if.dmem_enable       = den;
        bus_if.dmem_read_enable  = re;
        bus_if.dmem_write_enable = we;
        bus_if.dmem_address      = daddr;
        bus_if.dmem_write_data   = wdata;
        bus_if.dmem_write_mode   = wmode;
        bus_if.dmem_read_mode    = rmode;
        @(posedge clk);
        #1;
        bus_if.imem_enable       = 1'b0;
        bus_if.dmem_enable       = 1'b0;
        bus_if.dmem_read_enable  = 1'b0;
        bus_if.dmem_write_enable = 1'b0;
        istall = 0;
        dstall = 0;
        while ((bus_if.imem_wait || bus_if.dmem_wait) && n < 100) begin
            istall += int'(bus_if.imem_wait);
            dstall += int'(bus_if.dmem_wait);
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: waits still high after %0d cycles, expected release", n);
        end
        chk("xfers_done", exp_q.size(), 0);
        if (fen) exp_imem = ref_rd(faddr);
        if (dacc) begin
            if (we) ref_mem[daddr] = wdata;
            else    exp_dmem = ref_rd(daddr);
        end
    endtask

    typedef struct {
        string       name;
        bit          fen;
        logic [31:0] faddr;
        bit          den, re, we;
        logic [31:0] daddr, wdata;
        logic [2:0]  wmode, rmode;
        int          dly;
        int          exp_i, exp_d;
        logic [31:0] exp_idata, exp_ddata;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[7];
        int   ist, dst;

        vecs[0] = '{"fetch_100", 1, 32'h100, 0, 0, 0, 32'h0, 32'h0, MemModeByte, MemModeWord,
                    1, 1, 0, 32'h0000_0013, 32'h0};
        vecs[1] = '{"fetch_load", 1, 32'h104, 1, 1, 0, 32'h2000, 32'h0, MemModeByte, MemModeWord,
                    1, 2, 1, 32'h0010_0093, 32'h1234_5678};
        vecs[2] = '{"store_slow", 0, 32'h0, 1, 0, 1, 32'h2004, 32'hDEAD_BEEF, MemModeByte,
                    MemModeWord, 4, 0, 4, 32'h0010_0093, 32'h1234_5678};
        vecs[3] = '{"load_back", 0, 32'h0, 1, 1, 0, 32'h2004, 32'h0, MemModeByte, MemModeWord,
                    2, 0, 2, 32'h0010_0093, 32'hDEAD_BEEF};
        vecs[4] = '{"no_rw", 0, 32'h0, 1, 0, 0, 32'h3000, 32'h1111_1111, MemModeByte,
                    MemModeWord, 1, 0, 0, 32'h0010_0093, 32'hDEAD_BEEF};
        vecs[5] = '{"fetch_store_both", 1, 32'h100, 1, 1, 1, 32'h2008, 32'hCAFE_F00D,
                    MemModeHalf, MemModeWord, 2, 4, 2, 32'h0000_0013, 32'hDEAD_BEEF};
        vecs[6] = '{"load_bu", 0, 32'h0, 1, 1, 0, 32'h2008, 32'h0, MemModeByte, MemModeByteU,
                    1, 0, 1, 32'h0000_0013, 32'hCAFE_F00D};

        bus_mem[32'h100]  = 32'h0000_0013;  ref_mem[32'h100]  = 32'h0000_0013;
        bus_mem[32'h104]  = 32'h0010_0093;  ref_mem[32'h104]  = 32'h0010_0093;
        bus_mem[32'h2000] = 32'h1234_5678;  ref_mem[32'h2000] = 32'h1234_5678;

        reset_n = 1'b0;
        bus_if.imem_enable = 1'b0;  bus_if.imem_address = '0;
        bus_if.dmem_enable = 1'b0;  bus_if.dmem_read_enable = 1'b0;
        bus_if.dmem_write_enable = 1'b0;  bus_if.dmem_address = '0;
        bus_if.dmem_write_data = '0;  bus_if.dmem_write_mode = '0;  bus_if.dmem_read_mode = '0;
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
        chk("rst_imem_wait", {31'b0, bus_if.imem_wait}, 32'h0);
        chk("rst_dmem_wait", {31'b0, bus_if.dmem_wait}, 32'h0);
        chk("rst_imem_data", bus_if.imem_data, 32'h0);
        chk("rst_dmem_data", bus_if.dmem_read_data, 32'h0);

        // Directed vectors.
        rand_dly = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ack_delay = vecs[i].dly;
            do_op(vecs[i].fen, vecs[i].faddr, vecs[i].den, vecs[i].re, vecs[i].we,
                  vecs[i].daddr, vecs[i].wdata, vecs[i].wmode, vecs[i].rmode, ist, dst);
            chk({vecs[i].name, "_istall"}, ist, vecs[i].exp_i);
            chk({vecs[i].name, "_dstall"}, dst, vecs[i].exp_d);
            chk({vecs[i].name, "_imem_data"}, bus_if.imem_data, vecs[i].exp_idata);
            chk({vecs[i].name, "_dmem_data"}, bus_if.dmem_read_data, vecs[i].exp_ddata);
        end

        // Spurious ack in idle together with a data strobe that carries no access.
        spur_rd = 32'hBAD0_BAD0;
        spur_ack = 1'b1;
        bus_if.dmem_enable = 1'b1;
        bus_if.dmem_address = 32'h3000;
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
        bus_if.dmem_enable = 1'b0;
        chk("spur_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
        chk("spur_waits", {30'b0, bus_if.imem_wait, bus_if.dmem_wait}, 32'h0);
        @(posedge clk);
        #1;
        chk("spur_bus_req_late", {31'b0, bus_if.bus_req}, 32'h0);
        chk("spur_imem_data", bus_if.imem_data, 32'h0000_0013);
        chk("spur_dmem_data", bus_if.dmem_read_data, 32'hCAFE_F00D);

        // Reset in the middle of a transfer that is never acked.
        resp_en = 1'b0;
        bus_if.imem_enable = 1'b1;  bus_if.imem_address = 32'h104;
        bus_if.dmem_enable = 1'b1;  bus_if.dmem_read_enable = 1'b1;
        bus_if.dmem_address = 32'h2000;
        @(posedge clk);
        #1;
        bus_if.imem_enable = 1'b0;  bus_if.dmem_enable = 1'b0;  bus_if.dmem_read_enable = 1'b0;
        chk("abort_req_before", {31'b0, bus_if.bus_req}, 32'h1);
        chk("abort_waits_before", {30'b0, bus_if.imem_wait, bus_if.dmem_wait}, 32'h3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_req_async", {31'b0, bus_if.bus_req}, 32'h0);
        chk("abort_waits_async", {30'b0, bus_if.imem_wait, bus_if.dmem_wait}, 32'h0);
        chk("abort_imem_data", bus_if.imem_data, 32'h0);
        chk("abort_dmem_data", bus_if.dmem_read_data, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        exp_imem = '0;
        exp_dmem = '0;
        resp_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_retry_req", {31'b0, bus_if.bus_req}, 32'h0);
        chk("abort_no_retry_waits", {30'b0, bus_if.imem_wait, bus_if.dmem_wait}, 32'h0);

`ifdef MEM_ARB_STATS_EN
        ack_delay = 2;
        for (int i = 0; i < 5; i++) begin
            do_op(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MemModeByte,
                  MemModeWord, ist, dst);
        end
        chk("stat_istall", stat_istall, 32'd10);
        chk("stat_dstall", stat_dstall, 32'd0);
`endif

        // Randomized traffic against the memory model.
        rand_dly = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bit          fen = 1'($urandom);
            bit          den = 1'($urandom);
            bit          re = 1'($urandom);
            bit          we = 1'($urandom);
            bit          dacc = den && (re || we);
            int          exp_i, exp_d;
            logic [31:0] fa = 32'h8000 + 32'(4 * $urandom_range(15, 0));
            logic [31:0] da = 32'h4000 + 32'(4 * $urandom_range(7, 0));
            do_op(fen, fa, den, re, we, da, $urandom, 3'($urandom), 3'($urandom), ist, dst);
            chk("rnd_xfer_count", dly_q.size(), int'(fen) + int'(dacc));
            if (dly_q.size() == int'(fen) + int'(dacc)) begin
                exp_d = dacc ? dly_q[0] : 0;
                exp_i = !fen ? 0 : (dacc ? dly_q[0] + dly_q[1] : dly_q[0]);
                chk("rnd_istall", ist, exp_i);
                chk("rnd_dstall", dst, exp_d);
            end
            chk("rnd_imem_data", bus_if.imem_data, exp_imem);
            chk("rnd_dmem_data", bus_if.dmem_read_data, exp_dmem);
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
